periph_rx_arbiter: RTL
======================

PERIPH_RX_ARBITER -- requirements
Module: periph_rx_arbiter

Interface
REQ-001 Parameter NUM_PERIPHS, default 8: number of peripheral RX FIFOs served; legal range 2..16.
REQ-002 Parameter PACKET_WIDTH, default 32: USB packet width, equal to usb_packet_width.
REQ-003 Parameter GRANT_WIDTH, default $clog2(NUM_PERIPHS): width of the grant index.
REQ-004 clk  input  1  single block clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-006 rx_data  input  NUM_PERIPHS*PACKET_WIDTH  concatenated peripheral RX FIFO outputs, peripheral i at bits [i*PACKET_WIDTH +: PACKET_WIDTH].
REQ-007 rx_empty  input  NUM_PERIPHS  per-peripheral RX FIFO empty.
REQ-008 rx_almost_full  input  NUM_PERIPHS  per-peripheral RX FIFO almost-full (priority request).
REQ-009 periph_ready  input  NUM_PERIPHS  per-peripheral post-reset ready flag.
REQ-010 rx_read  output  NUM_PERIPHS  per-peripheral RX FIFO read strobe.
REQ-011 out_data  output  PACKET_WIDTH  packet toward the USB write path.
REQ-012 out_valid  output  1  out_data holds a valid packet.
REQ-013 out_ready  input  1  downstream accepts out_data this cycle when out_valid is high.
REQ-014 grant_id  output  GRANT_WIDTH  index of the peripheral whose packet is on out_data.
REQ-015 pkt_count  output  16  total packets accepted downstream.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The block SHALL implement states IDLE, READ, CAPTURE, SEND.
REQ-018 In IDLE, peripheral i SHALL be eligible iff rx_empty[i]=0 and periph_ready[i]=1.
REQ-019 Grant selection SHALL be round-robin, scanning from last_grant+1 upward and wrapping NUM_PERIPHS-1 -> 0.
REQ-020 If any eligible peripheral has rx_almost_full=1, the scan SHALL consider only those peripherals; otherwise it SHALL consider all eligible peripherals.
REQ-021 If at least one peripheral is eligible, IDLE SHALL register the grant and go to READ; otherwise it SHALL stay in IDLE.
REQ-022 In READ, rx_read SHALL be one-hot at the granted index for exactly one cycle; the next state SHALL be CAPTURE.
REQ-023 rx_read SHALL be all-zero in every state other than READ.
REQ-024 In CAPTURE, the granted rx_data slice (1-cycle FIFO read latency) SHALL be registered into out_data unmodified, with grant_id set; the next state SHALL be SEND.
REQ-025 In SEND, out_valid SHALL be 1 and out_data/grant_id SHALL be held stable until out_ready=1.
REQ-026 On a cycle with out_valid=1 and out_ready=1: next state IDLE, last_grant <= grant, pkt_count increments (wrapping 0xFFFF -> 0).
REQ-027 Latency SHALL be: first eligible cycle in IDLE -> out_valid high 3 cycles later; peak throughput SHALL be 1 packet per 4 cycles.
REQ-028 Eligibility SHALL be sampled only in IDLE; rx_empty, rx_almost_full or periph_ready changing after the grant SHALL NOT abort or alter the transfer.
REQ-029 out_ready asserted outside SEND SHALL have no effect.

Reset
REQ-030 While rst_n=0: state IDLE, rx_read=0, out_valid=0, out_data=0, grant_id=0, pkt_count=0, busy=0, last_grant=NUM_PERIPHS-1 (so the first scan starts at index 0).
REQ-031 Reset asserted mid-transfer SHALL discard the packet in flight with no further rx_read pulse; the first transfer after reset SHALL start from IDLE.

Verification
REQ-032 Single packet: peripheral 3 non-empty and ready, out_ready=1 -> rx_read[3] high for exactly 1 cycle; out_valid high 3 cycles after the first eligible cycle; out_data equals the slice-3 data; grant_id=3; pkt_count=1.
REQ-033 Round-robin: peripherals 0, 2, 5 permanently non-empty, no almost-full -> grants in order 0, 2, 5, 0, 2.
REQ-034 Priority: peripherals 1 and 6 non-empty, almost-full only on 6, last_grant=0 -> next grant is 6.
REQ-035 Backpressure: out_ready=0 for 10 cycles in SEND -> out_valid and out_data stable, no rx_read pulse; the transfer completes on the cycle out_ready rises.
REQ-036 Gating: periph_ready[4]=0 with rx_empty[4]=0 -> peripheral 4 never granted; rx_empty deasserting during READ -> the transfer still completes.
REQ-037 Reset: rst_n pulled low during CAPTURE -> outputs immediately at reset values; pkt_count=0; last_grant restored so the first post-reset scan starts at index 0.

Source files
------------

// File: rtl/periph_rx_arbiter.sv
// Round-robin arbiter draining peripheral RX FIFOs into a single USB write path.
// Almost-full peripherals take precedence; one packet moves per IDLE->READ->CAPTURE->SEND pass.
module periph_rx_arbiter #(
  parameter int NUM_PERIPHS  = 8,
  parameter int PACKET_WIDTH = 32,
  parameter int GRANT_WIDTH  = $clog2(NUM_PERIPHS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_PERIPHS*PACKET_WIDTH-1:0] rx_data,
  input  logic [NUM_PERIPHS-1:0]              rx_empty,
  input  logic [NUM_PERIPHS-1:0]              rx_almost_full,
  input  logic [NUM_PERIPHS-1:0]              periph_ready,
  output logic [NUM_PERIPHS-1:0]              rx_read,
  output logic [PACKET_WIDTH-1:0]             out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [GRANT_WIDTH-1:0]              grant_id,
  output logic [15:0]                         pkt_count,
  output logic                                busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_READ    = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_SEND    = 2'd3;

  logic [1:0]              state;
  logic [GRANT_WIDTH-1:0]  grant;
  logic [GRANT_WIDTH-1:0]  last_grant;
  logic [GRANT_WIDTH-1:0]  next_grant;
  logic [NUM_PERIPHS-1:0]  eligible;
  logic [NUM_PERIPHS-1:0]  urgent;
  logic [NUM_PERIPHS-1:0]  candidates;
  logic [PACKET_WIDTH-1:0] slices [NUM_PERIPHS];

  for (genvar i = 0; i < NUM_PERIPHS; i++) begin : g_slice
    assign slices[i] = rx_data[i*PACKET_WIDTH +: PACKET_WIDTH];
  end

  // Peripheral index reached 'offset' steps after 'base', wrapping at NUM_PERIPHS.
  function automatic logic [GRANT_WIDTH-1:0] scan_index(input logic [GRANT_WIDTH-1:0] base,
                                                        input int offset);
    return GRANT_WIDTH'((int'(base) + offset) % NUM_PERIPHS);
  endfunction

  assign eligible   = ~rx_empty & periph_ready;
  assign urgent     = eligible & rx_almost_full;
  assign candidates = (|urgent) ? urgent : eligible;

  // Scan from farthest to nearest so the candidate closest after last_grant wins.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    next_grant = last_grant;
    for (int k = NUM_PERIPHS; k >= 1; k--) begin
      if (candidates[scan_index(last_grant, k)]) begin
        next_grant = scan_index(last_grant, k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= GRANT_WIDTH'(NUM_PERIPHS - 1);
      out_data   <= '0;
      grant_id   <= '0;
      pkt_count  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      case (state)
        ST_IDLE: begin
          if (|candidates) begin
            grant <= next_grant;
            state <= ST_READ;
          end
        end
        ST_READ: state <= ST_CAPTURE;
        ST_CAPTURE: begin
          // FIFO data for the READ strobe is valid one cycle later, i.e. now.
          out_data <= slices[grant];
          grant_id <= grant;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          if (out_ready) begin
            last_grant <= grant;
            pkt_count  <= pkt_count + 16'd1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rx_read   = (state == ST_READ) ? (NUM_PERIPHS'(1) << grant) : '0;
  assign out_valid = (state == ST_SEND);
  assign busy      = (state != ST_IDLE);

endmodule
